// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if: request/response bundle for alu_exec_seq; master drives in_valid, alu_op, opcode, funct, shamt, a, b and receives in_ready, result, hi, done, zero, ovf, illegal
interface alu_exec_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             done;
  logic             zero;
  logic             ovf;
  logic             illegal;
  modport master (
    output in_valid, alu_op, opcode, funct, shamt, a, b,
    input  in_ready, result, hi, done, zero, ovf, illegal
  );
  modport slave (
    input  in_valid, alu_op, opcode, funct, shamt, a, b,
    output in_ready, result, hi, done, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: EX-stage ALU with decode, registered single-cycle ops and iterative MUL (plus restoring DIV when ALU_DIV_EN is defined); ports clk, rst, bus (alu_exec_seq_if.slave)
module alu_exec_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  alu_exec_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd11;
`endif
  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef ALU_DIV_EN
    , DIV
`endif
  } state_e;
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               illegal_q, illegal_d;
  logic [3:0]         op;
  logic               bad;
  logic               sub;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_ovf;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] step;
  logic               last;
  always_comb begin
    op  = OP_ADD;
    bad = 1'b0;
    case (bus.alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10:
        case (bus.funct)
          6'd36: op = OP_AND;
          6'd37: op = OP_OR;
          6'd32: op = OP_ADD;
          6'd34: op = OP_SUB;
          6'd42: op = OP_SLT;
          6'd39: op = OP_NOR;
          6'd38: op = OP_XOR;
          6'd0:  op = OP_SLL;
          6'd2:  op = OP_SRL;
          6'd24: op = OP_MUL;
`ifdef ALU_DIV_EN
          6'd26: op = OP_DIV;
`endif
          default: bad = 1'b1;
        endcase
      default:
        case (bus.opcode)
          6'd15: op = OP_LUI;
          6'd10: op = OP_SLT;
          6'd8:  op = OP_ADD;
          6'd13: op = OP_OR;
          6'd14: op = OP_XOR;
          6'd12: op = OP_AND;
          default: bad = 1'b1;
        endcase
    endcase
  end
  assign sub     = op == OP_SUB;
  assign bx      = sub ? ~bus.b : bus.b;
  assign sum     = bus.a + bx + WIDTH'(sub);
  assign alu_ovf = (op == OP_ADD || sub) && bus.a[WIDTH-1] == bx[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
  always_comb begin
    alu_y = sum;
    case (op)
      OP_AND:  alu_y = bus.a & bus.b;
      OP_OR:   alu_y = bus.a | bus.b;
      OP_SLL:  alu_y = bus.b << bus.shamt;
      OP_SRL:  alu_y = bus.b >> bus.shamt;
      OP_LUI:  alu_y = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  alu_y = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_NOR:  alu_y = ~(bus.a | bus.b);
      OP_XOR:  alu_y = bus.a ^ bus.b;
      default: alu_y = sum;
    endcase
  end
  assign madd     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {madd, prod_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     dsub;
  logic [2*WIDTH-1:0] div_step;
  assign shifted  = prod_q[2*WIDTH-1:WIDTH-1];
  assign dsub     = shifted - {1'b0, mcand_q};
  assign div_step = dsub[WIDTH] ? {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0} : {dsub[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign step     = state_q == DIV ? div_step : mul_step;
`else
  assign step     = mul_step;
`endif
  assign last = cnt_q == SHW'(WIDTH - 1);
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    if (state_q == IDLE) begin
      if (bus.in_valid) begin
        if (op == OP_MUL) begin
          state_d = MUL;
          prod_d  = {{WIDTH{1'b0}}, bus.b};
          mcand_d = bus.a;
          cnt_d   = '0;
        end
`ifdef ALU_DIV_EN
        else if (op == OP_DIV && bus.b != '0) begin
          state_d = DIV;
          prod_d  = {{WIDTH{1'b0}}, bus.a};
          mcand_d = bus.b;
          cnt_d   = '0;
        end else if (op == OP_DIV) begin
          result_d  = '1;
          hi_d      = bus.a;
          zero_d    = 1'b0;
          ovf_d     = 1'b0;
          illegal_d = 1'b1;
          done_d    = 1'b1;
        end
`endif
        else begin
          result_d  = alu_y;
          zero_d    = alu_y == '0;
          ovf_d     = alu_ovf;
          illegal_d = bad;
          done_d    = 1'b1;
        end
      end
    end else begin
      prod_d = step;
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        state_d   = IDLE;
        result_d  = step[WIDTH-1:0];
        hi_d      = step[2*WIDTH-1:WIDTH];
        zero_d    = step[WIDTH-1:0] == '0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      hi_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.in_ready = state_q == IDLE && !rst;
  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.done     = done_q;
  assign bus.zero     = zero_q;
  assign bus.ovf      = ovf_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: table vectors and multi-cycle sequences against a completion scoreboard for alu_exec_seq
module tb_alu_exec_seq;
  localparam int W = 32;
  typedef struct {
    logic [1:0]   alu_op;
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [4:0]   shamt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         ill;
  } vec_t;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         ill;
    int           due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0;
  exp_t sb[$];
  vec_t vt[22];
  alu_exec_seq_if #(.WIDTH(W)) bus();
  alu_exec_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, req, cyc);
    end
  endtask
  task automatic drive(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] fn, input logic [4:0] sh, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.alu_op   = op;
    bus.opcode   = oc;
    bus.funct    = fn;
    bus.shamt    = sh;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
  endtask
  task automatic send(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] fn, input logic [4:0] sh, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] hi, input logic ovf, input logic ill, input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    drive(op, oc, fn, sh, a, b);
    e.res = res;
    e.hi  = hi;
    e.ovf = ovf;
    e.ill = ill;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask
  task automatic release_valid();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_idle(input string n);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready && sb.size() == 0;
    end
    chk(n, {63'd0, ok}, 64'd1);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 result=%h, required no completion (cycle %0d)", bus.result, cyc);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("zero", 64'(bus.zero), 64'(e.res == '0));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        chk("illegal", 64'(bus.illegal), 64'(e.ill));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end
  initial begin
    logic [63:0] p;
    bit busy_ok;
    vt[0]  = '{2'b10, 6'd0,  6'd37, 5'd0,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
    vt[1]  = '{2'b11, 6'd15, 6'd0,  5'd0,  32'h0,        32'h00001234, 32'h12340000, 1'b0, 1'b0};
    vt[2]  = '{2'b10, 6'd0,  6'd63, 5'd0,  32'd10,       32'd20,       32'd30,       1'b0, 1'b1};
    vt[3]  = '{2'b00, 6'd0,  6'd0,  5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0};
    vt[4]  = '{2'b01, 6'd0,  6'd0,  5'd0,  32'd5,        32'd5,        32'd0,        1'b0, 1'b0};
    vt[5]  = '{2'b10, 6'd0,  6'd42, 5'd0,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0};
    vt[6]  = '{2'b10, 6'd0,  6'd42, 5'd0,  32'h1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    vt[7]  = '{2'b10, 6'd0,  6'd36, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0};
    vt[8]  = '{2'b10, 6'd0,  6'd39, 5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
    vt[9]  = '{2'b10, 6'd0,  6'd38, 5'd0,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0};
    vt[10] = '{2'b10, 6'd0,  6'd0,  5'd4,  32'h0,        32'h00000F01, 32'h0000F010, 1'b0, 1'b0};
    vt[11] = '{2'b10, 6'd0,  6'd2,  5'd31, 32'h0,        32'h80000000, 32'h1,        1'b0, 1'b0};
    vt[12] = '{2'b10, 6'd0,  6'd2,  5'd4,  32'h0,        32'hF0000000, 32'h0F000000, 1'b0, 1'b0};
    vt[13] = '{2'b01, 6'd0,  6'd0,  5'd0,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0};
    vt[14] = '{2'b11, 6'd10, 6'd0,  5'd0,  32'd5,        32'd3,        32'h0,        1'b0, 1'b0};
    vt[15] = '{2'b11, 6'd8,  6'd0,  5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0};
    vt[16] = '{2'b11, 6'd13, 6'd0,  5'd0,  32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0};
    vt[17] = '{2'b11, 6'd14, 6'd0,  5'd0,  32'hFF,       32'h0F,       32'hF0,       1'b0, 1'b0};
    vt[18] = '{2'b11, 6'd12, 6'd0,  5'd0,  32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b0};
    vt[19] = '{2'b11, 6'd63, 6'd0,  5'd0,  32'd1,        32'd2,        32'd3,        1'b0, 1'b1};
    vt[20] = '{2'b10, 6'd0,  6'd32, 5'd0,  32'd3,        32'd4,        32'd7,        1'b0, 1'b0};
    vt[21] = '{2'b10, 6'd0,  6'd34, 5'd0,  32'd3,        32'd4,        32'hFFFFFFFF, 1'b0, 1'b0};
    bus.in_valid = 1'b0;
    drive(2'b00, 6'd0, 6'd0, 5'd0, '0, '0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
    foreach (vt[i]) begin
      send(vt[i].alu_op, vt[i].opcode, vt[i].funct, vt[i].shamt, vt[i].a, vt[i].b, vt[i].res, m_hi, vt[i].ovf, vt[i].ill, 1);
      chk("ready_b2b", 64'(bus.in_ready), 64'd1);
    end
    release_valid();
    wait_idle("drain_table");
    p = 64'h00000000FFFFFFFF * 64'd2;
    m_hi = p[63:32];
    send(2'b10, 6'd0, 6'd24, 5'd0, 32'hFFFFFFFF, 32'd2, p[31:0], m_hi, 1'b0, 1'b0, 33);
    release_valid();
    bus.alu_op = 2'b00;
    busy_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      bus.in_valid = (i == 5 || i == 20);
    end
    bus.in_valid = 1'b0;
    chk("mul_busy_ready_low", {63'd0, busy_ok}, 64'd1);
    @(negedge clk);
    chk("mul_done_cycle33", 64'(bus.done), 64'd1);
    chk("mul_ready_in_done", 64'(bus.in_ready), 64'd1);
    wait_idle("drain_mul1");
    p = 64'h0000000012345678 * 64'h000000009ABCDEF0;
    m_hi = p[63:32];
    send(2'b10, 6'd0, 6'd24, 5'd0, 32'h12345678, 32'h9ABCDEF0, p[31:0], m_hi, 1'b0, 1'b0, 33);
    release_valid();
    wait_idle("drain_mul2");
    send(2'b10, 6'd0, 6'd37, 5'd0, 32'h1, 32'h2, 32'h3, m_hi, 1'b0, 1'b0, 1);
    release_valid();
    wait_idle("drain_hi_hold");
    @(posedge clk);
    #1;
    drive(2'b10, 6'd0, 6'd24, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    release_valid();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_zero", 64'(bus.zero), 64'd0);
    chk("abort_illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    m_hi = '0;
    @(negedge clk);
    chk("abort_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) @(negedge clk);
    send(2'b00, 6'd0, 6'd0, 5'd0, 32'd9, 32'd1, 32'd10, m_hi, 1'b0, 1'b0, 1);
    release_valid();
    wait_idle("drain_abort");
`ifdef ALU_DIV_EN
    m_hi = 32'd2;
    send(2'b10, 6'd0, 6'd26, 5'd0, 32'd100, 32'd7, 32'd14, m_hi, 1'b0, 1'b0, 33);
    release_valid();
    wait_idle("drain_div");
    m_hi = 32'd55;
    send(2'b10, 6'd0, 6'd26, 5'd0, 32'd55, 32'd0, 32'hFFFFFFFF, m_hi, 1'b0, 1'b1, 1);
    release_valid();
    wait_idle("drain_div0");
`else
    send(2'b10, 6'd0, 6'd26, 5'd0, 32'd10, 32'd20, 32'd30, m_hi, 1'b0, 1'b1, 1);
    release_valid();
    wait_idle("drain_nodiv");
`endif
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
